// File: rtl/bitstream_decimator_if.sv
// Sample/control and result signals of the delta-sigma bitstream decimator.
interface bitstream_decimator_if #(parameter int BITS = 7);
    logic            EN;
    logic            BS_IN;
    logic            SYNC;
    logic [BITS-1:0] VALUE_OUT;
    logic            SIGN_OUT;
    logic            VALID;
    logic            CHANGED;
    logic            LOCKED;

    modport master (output EN, BS_IN, SYNC,
                    input  VALUE_OUT, SIGN_OUT, VALID, CHANGED, LOCKED);
    modport slave  (input  EN, BS_IN, SYNC,
                    output VALUE_OUT, SIGN_OUT, VALID, CHANGED, LOCKED);
endinterface

// File: rtl/bitstream_decimator.sv
// Integrates a first-order delta-sigma bitstream over 2*K-sample windows and
// reports the recovered value as sign plus saturated magnitude.
module bitstream_decimator #(
    parameter int K    = 127,
    parameter int BITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    bitstream_decimator_if.slave  bus
);
    typedef enum logic {PRIME, RUN} state_t;

    localparam logic [BITS:0]          N_LAST  = (BITS+1)'(2*K-1);
    localparam logic signed [BITS+1:0] K_S     = (BITS+2)'(K);
    localparam logic [BITS-1:0]        MAG_MAX = '1;
    // MSB set marks "no previous result", so the first RUN window always differs
    localparam logic [BITS+1:0]        PREV_NONE = {1'b1, {(BITS+1){1'b0}}};

    state_t            state_q, state_d;
    logic [BITS:0]     win_cnt;
    logic [BITS:0]     ones_cnt;
    logic [BITS+1:0]   prev_word;

    logic                  sample, win_end, emit, lock_set;
    logic [BITS:0]         ones_next;
    logic signed [BITS+1:0] diff, diff_abs;
    logic                  dec_sign;
    logic [BITS-1:0]       dec_mag;
    logic [BITS+1:0]       dec_word;

    function automatic logic [BITS-1:0] sat_mag(input logic signed [BITS+1:0] m);
        if (m > signed'({2'b00, MAG_MAX}))
            return MAG_MAX;
        else
            return m[BITS-1:0];
    endfunction

    always_comb begin
        ones_next = ones_cnt + {{BITS{1'b0}}, bus.BS_IN};
        diff      = signed'({1'b0, ones_next}) - K_S;
        dec_sign  = (diff >= 0);
        diff_abs  = dec_sign ? diff : -diff;
        dec_mag   = sat_mag(diff_abs);
        dec_word  = {1'b0, dec_sign, dec_mag};
    end

    always_comb begin
        state_d  = state_q;
        sample   = bus.EN && !bus.SYNC;
        win_end  = sample && (win_cnt == N_LAST);
        emit     = 1'b0;
        lock_set = 1'b0;
        if (bus.SYNC) begin
            state_d = PRIME;
        end else if (win_end) begin
            case (state_q)
                PRIME: begin
                    state_d  = RUN;
                    lock_set = 1'b1;
                end
                RUN:     emit    = 1'b1;
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PRIME;
            win_cnt       <= '0;
            ones_cnt      <= '0;
            prev_word     <= PREV_NONE;
            bus.VALUE_OUT <= '0;
            bus.SIGN_OUT  <= 1'b1;
            bus.VALID     <= 1'b0;
            bus.CHANGED   <= 1'b0;
            bus.LOCKED    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus.VALID   <= emit;
            bus.CHANGED <= emit && (dec_word != prev_word);
            if (bus.SYNC) begin
                win_cnt    <= '0;
                ones_cnt   <= '0;
                bus.LOCKED <= 1'b0;
            end else if (sample) begin
                if (win_end) begin
                    win_cnt  <= '0;
                    ones_cnt <= '0;
                end else begin
                    win_cnt  <= win_cnt + {{BITS{1'b0}}, 1'b1};
                    ones_cnt <= ones_next;
                end
            end
            if (lock_set) begin
                bus.LOCKED <= 1'b1;
                prev_word  <= PREV_NONE;
            end
            if (emit) begin
                bus.VALUE_OUT <= dec_mag;
                bus.SIGN_OUT  <= dec_sign;
                prev_word     <= dec_word;
            end
        end
    end
endmodule

// File: tb/tb_bitstream_decimator.sv
// Directed and randomized checks of bitstream_decimator against a window-level model.
module tb_bitstream_decimator;
    localparam int K    = 127;
    localparam int BITS = 7;
    localparam int N    = 2*K;
    localparam int MAXV = (1 << BITS) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitstream_decimator_if #(.BITS(BITS)) bus();
    bitstream_decimator #(.K(K), .BITS(BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0;
    int n_valid = 0;

    // Model: samples of the current window, count of completed windows since restart
    bit q[$];
    int windows = 0;
    int m_val = 0;
    bit m_sign = 1'b1;
    bit have_last = 1'b0;
    bit exp_valid, exp_changed;
    bit range_chk = 1'b0;
    int rlo = 0, rhi = 0;
    bit rsign = 1'b1;
    int acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit en, input bit bs, input bit sy, input bit r);
        int ones, d, mag;
        bit sgn;
        bus.EN = en; bus.BS_IN = bs; bus.SYNC = sy; rst = r;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_changed = 1'b0;
        if (r) begin
            q.delete(); windows = 0; m_val = 0; m_sign = 1'b1; have_last = 1'b0;
        end else if (sy) begin
            q.delete(); windows = 0; have_last = 1'b0;
        end else if (en) begin
            q.push_back(bs);
            if (q.size() == N) begin
                ones = 0;
                foreach (q[i]) ones += int'(q[i]);
                q.delete();
                windows++;
                if (windows >= 2) begin
                    d   = ones - K;
                    sgn = (d >= 0);
                    mag = (d < 0) ? -d : d;
                    if (mag > MAXV) mag = MAXV;
                    exp_valid   = 1'b1;
                    exp_changed = !have_last || (mag != m_val) || (sgn != m_sign);
                    have_last   = 1'b1;
                    m_val  = mag;
                    m_sign = sgn;
                end
            end
        end
        if (bus.VALID === 1'b1) n_valid++;
        chk("valid",   32'(bus.VALID),     32'(exp_valid));
        chk("changed", 32'(bus.CHANGED),   32'(exp_changed));
        chk("locked",  32'(bus.LOCKED),    32'(windows >= 1));
        chk("value",   32'(bus.VALUE_OUT), 32'(m_val));
        chk("sign",    32'(bus.SIGN_OUT),  32'(m_sign));
        if (range_chk && exp_valid) begin
            chk("mod_range", 32'(int'(bus.VALUE_OUT) >= rlo && int'(bus.VALUE_OUT) <= rhi), 32'd1);
            chk("mod_sign",  32'(bus.SIGN_OUT), 32'(rsign));
        end
    endtask

    // First-order delta-sigma modulator with full-scale K
    function automatic bit mod_bit(input int x);
        bit y;
        acc += x;
        y = (acc >= 0);
        acc -= y ? K : -K;
        return y;
    endfunction

    initial begin
        bus.EN = 1'b0; bus.BS_IN = 1'b0; bus.SYNC = 1'b0; rst = 1'b1;

        // Reset state
        step(0, 0, 0, 1);
        chk("rst_valid",  32'(bus.VALID),     32'd0);
        chk("rst_locked", 32'(bus.LOCKED),    32'd0);
        chk("rst_value",  32'(bus.VALUE_OUT), 32'd0);
        chk("rst_sign",   32'(bus.SIGN_OUT),  32'd1);

        // Alternating stream decodes to zero; priming window gives no VALID
        n_valid = 0;
        for (int i = 0; i < N; i++) step(1, bit'(i % 2 == 0), 0, 0);
        chk("s1_locked_at_N", 32'(bus.LOCKED), 32'd1);
        chk("s1_no_valid_prime", 32'(n_valid), 32'd0);
        for (int i = 0; i < N; i++) step(1, bit'(i % 2 == 0), 0, 0);
        chk("s1_first_valid", 32'(n_valid), 32'd1);
        for (int i = 0; i < N; i++) step(1, bit'(i % 2 == 0), 0, 0);
        chk("s1_second_valid", 32'(n_valid), 32'd2);

        // Full scale positive then negative
        for (int i = 0; i < 3*N; i++) step(1, 1, 0, 0);
        chk("s2_pos_full", 32'(bus.VALUE_OUT), 32'd127);
        for (int i = 0; i < 3*N; i++) step(1, 0, 0, 0);
        chk("s2_neg_full", 32'(bus.SIGN_OUT), 32'd0);

        // Modulator loop at +50 then -50
        range_chk = 1'b1; rlo = 49; rhi = 51;
        rsign = 1'b1; acc = 0;
        step(1, 0, 1, 0);
        for (int i = 0; i < 5*N; i++) step(1, mod_bit(50), 0, 0);
        rsign = 1'b0; acc = 0;
        step(1, 0, 1, 0);
        for (int i = 0; i < 5*N; i++) step(1, mod_bit(-50), 0, 0);
        range_chk = 1'b0;

        // 50% EN with noise on idle cycles
        step(0, 0, 0, 1);
        n_valid = 0;
        for (int i = 0; i < 2*2*N; i++) begin
            if (i % 2 == 1) step(1, bit'((i/2) % 2 == 0), 0, 0);
            else            step(0, bit'($urandom_range(0, 1)), 0, 0);
        end
        chk("s4_first_valid_1016", 32'(n_valid), 32'd1);

        // SYNC mid-window, then SYNC on a window's final sample
        for (int i = 0; i < 100; i++) step(1, bit'(i % 2 == 0), 0, 0);
        step(1, 1, 1, 0);
        chk("s5_sync_unlock", 32'(bus.LOCKED), 32'd0);
        n_valid = 0;
        for (int i = 0; i < 2*N; i++) step(1, bit'(i % 3 == 0), 0, 0);
        chk("s5_valid_after_sync", 32'(n_valid), 32'd1);
        for (int i = 0; i < N-1; i++) step(1, 1, 0, 0);
        n_valid = 0;
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        chk("s5_sync_final_no_valid", 32'(n_valid), 32'd0);

        // Reset mid RUN window, then a full sequence again
        for (int i = 0; i < N-1; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 200; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        chk("s6_rst_value", 32'(bus.VALUE_OUT), 32'd0);
        chk("s6_rst_sign",  32'(bus.SIGN_OUT),  32'd1);
        for (int i = 0; i < 3*N; i++) step(1, bit'(i % 4 != 0), 0, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++)
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1499) == 0), bit'($urandom_range(0, 2999) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
